mat_stream_loader: RTL and testbench

Upstream feeder for the 3x3 matrix multiplier. Accepts a serial stream of 16-bit elements over a valid/ready handshake and assembles two row-major packed matrices, A then B, into a shadow buffer. It then presents them on stable output registers with `mult_en` asserted until the multiplier acknowledges. Double buffering allows the next A/B pair to stream in while the current pair is held.

---
 rtl/mat_pkg.sv | 11 +
 rtl/mat_stream_loader.sv | 91 +++++++++
 tb/tb_mat_stream_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// Shared sizing and types for the 3x3 matrix multiplier front end.
package mat_pkg;
   localparam int ELEM_W      = 16;
   localparam int DIM         = 3;
   localparam int NUM_ELEM    = DIM * DIM;
   localparam int MAT_W       = NUM_ELEM * ELEM_W;
   localparam int FRAME_BEATS = 2 * NUM_ELEM;

   typedef logic [ELEM_W-1:0] elem_t;
   typedef logic [MAT_W-1:0]  mat_t;
endpackage

// File: rtl/mat_stream_loader.sv
// Assembles A/B matrix pairs from an element stream into a shadow buffer and
// hands them to the multiplier through held output registers (double buffered).
module mat_stream_loader #(
   parameter int ELEM_W = mat_pkg::ELEM_W,
   parameter int DIM    = mat_pkg::DIM
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [ELEM_W-1:0]               in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            in_last,
   output logic [DIM*DIM*ELEM_W-1:0]       matrix_a_stream,
   output logic [DIM*DIM*ELEM_W-1:0]       matrix_b_stream,
   output logic                            mult_en,
   input  logic                            mult_ack,
   output logic                            frame_err
);
   import mat_pkg::*;

   localparam int          N_ELEM   = DIM * DIM;
   localparam int          M_W      = N_ELEM * ELEM_W;
   localparam logic [4:0]  LAST_IDX = 5'(2 * N_ELEM - 1);

   logic [4:0]     idx;
   logic           sh_full;
   logic [M_W-1:0] sh_a;
   logic [M_W-1:0] sh_b;

   logic beat;
   logic at_last;
   logic frame_done;
   logic violation;
   logic transfer;
   logic release_en;

   assign in_ready   = !sh_full && !rst;
   assign beat       = in_valid && in_ready;
   assign at_last    = (idx == LAST_IDX);
   assign frame_done = beat && at_last && in_last;
   assign violation  = beat && (in_last != at_last);
   assign transfer   = sh_full && (!mult_en || mult_ack);
   assign release_en = mult_ack && mult_en && !sh_full;

   // Control: beat counter, shadow-full flag, handshake to the multiplier
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         sh_full   <= 1'b0;
         mult_en   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= violation;
         if (beat) begin
            if (violation || frame_done)
               idx <= '0;
            else
               idx <= idx + 5'd1;
         end
         if (frame_done)
            sh_full <= 1'b1;
         else if (transfer)
            sh_full <= 1'b0;
         if (transfer)
            mult_en <= 1'b1;
         else if (release_en)
            mult_en <= 1'b0;
      end
   end

   // Shadow buffer is data only; a partial frame is abandoned by rewinding idx
   always_ff @(posedge clk) begin
      for (int k = 0; k < N_ELEM; k++) begin
         if (beat && idx == 5'(k))
            sh_a[(N_ELEM-k)*ELEM_W-1 -: ELEM_W] <= in_data;
         if (beat && idx == 5'(k + N_ELEM))
            sh_b[(N_ELEM-k)*ELEM_W-1 -: ELEM_W] <= in_data;
      end
   end

   // Output registers move only on a transfer edge so the multiplier sees stable operands
   always_ff @(posedge clk) begin
      if (rst) begin
         matrix_a_stream <= '0;
         matrix_b_stream <= '0;
      end else if (transfer) begin
         matrix_a_stream <= sh_a;
         matrix_b_stream <= sh_b;
      end
   end
endmodule

// File: tb/tb_mat_stream_loader.sv
// Scoreboard bench for mat_stream_loader: frames queued on send, checked on load.
module tb_mat_stream_loader;
   import mat_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   elem_t       in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_last = 1'b0;
   mat_t        matrix_a_stream;
   mat_t        matrix_b_stream;
   logic        mult_en;
   logic        mult_ack = 1'b0;
   logic        frame_err;

   typedef struct {
      mat_t a;
      mat_t b;
   } pair_t;

   pair_t sb_q[$];
   int    checks   = 0;
   int    failures = 0;

   always #5 clk = ~clk;

   mat_stream_loader dut (
      .clk             (clk),
      .rst             (rst),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_last         (in_last),
      .matrix_a_stream (matrix_a_stream),
      .matrix_b_stream (matrix_b_stream),
      .mult_en         (mult_en),
      .mult_ack        (mult_ack),
      .frame_err       (frame_err)
   );

   task automatic chk(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   function automatic mat_t pack(input int base);
      mat_t m = '0;
      for (int k = 0; k < NUM_ELEM; k++)
         m[(NUM_ELEM-k)*ELEM_W-1 -: ELEM_W] = ELEM_W'(base + k);
      return m;
   endfunction

   // Drives one beat and waits (bounded) for it to be accepted
   task automatic send_beat(input int val, input logic last);
      int budget = 0;
      @(negedge clk);
      in_data  = ELEM_W'(val);
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) chk("beat_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input int base_a, input int base_b, input logic push);
      pair_t p;
      if (push) begin
         p.a = pack(base_a);
         p.b = pack(base_b);
         sb_q.push_back(p);
      end
      for (int k = 0; k < NUM_ELEM; k++) send_beat(base_a + k, 1'b0);
      for (int k = 0; k < NUM_ELEM; k++) send_beat(base_b + k, push && (k == NUM_ELEM-1));
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      mult_ack = 1'b1;
      @(posedge clk);
      #1;
      mult_ack = 1'b0;
   endtask

   // Monitor: every new pair presented must be the oldest queued frame
   mat_t prev_a = '0;
   mat_t prev_b = '0;
   logic prev_en = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (mult_en && (!prev_en || matrix_a_stream != prev_a || matrix_b_stream != prev_b)) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_load", 0, 1);
            end else begin
               pair_t p;
               p = sb_q.pop_front();
               chk("load_a", matrix_a_stream, p.a);
               chk("load_b", matrix_b_stream, p.b);
            end
         end else if (!mult_en && (matrix_a_stream != prev_a || matrix_b_stream != prev_b)) begin
            chk("idle_hold_a", matrix_a_stream, prev_a);
         end
      end
      prev_a  = matrix_a_stream;
      prev_b  = matrix_b_stream;
      prev_en = mult_en;
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mult_en", mult_en, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_mat_a", matrix_a_stream, 0);
      chk("rst_mat_b", matrix_b_stream, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);

      // Nominal frame and latency
      send_frame(1, 10, 1'b1);
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      chk("lat_mult_en_lo", mult_en, 0);
      @(negedge clk);
      chk("lat_mult_en_hi", mult_en, 1);
      chk("xfer_in_ready", in_ready, 1);
      repeat (3) @(negedge clk);
      chk("hold_mult_en", mult_en, 1);

      // Overlap and stall
      send_frame(100, 109, 1'b1);
      repeat (4) @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_mat_a", matrix_a_stream, pack(1));
      chk("stall_mat_b", matrix_b_stream, pack(10));
      chk("stall_mult_en", mult_en, 1);
      pulse_ack();
      @(negedge clk);
      chk("b2b_mult_en", mult_en, 1);
      chk("b2b_mat_a", matrix_a_stream, pack(100));
      chk("b2b_in_ready", in_ready, 1);

      // Release, then ack with nothing held
      pulse_ack();
      @(negedge clk);
      chk("rel_mult_en", mult_en, 0);
      chk("rel_mat_a", matrix_a_stream, pack(100));
      chk("rel_mat_b", matrix_b_stream, pack(109));
      pulse_ack();
      @(negedge clk);
      chk("idle_ack_mult_en", mult_en, 0);
      chk("idle_ack_mat_a", matrix_a_stream, pack(100));

      // Early in_last on beat 5
      for (int k = 0; k < 5; k++) send_beat(50 + k, 1'b0);
      @(negedge clk);
      chk("early_no_err", frame_err, 0);
      send_beat(55, 1'b1);
      @(negedge clk);
      chk("early_err_hi", frame_err, 1);
      @(negedge clk);
      chk("early_err_lo", frame_err, 0);
      chk("early_mat_a", matrix_a_stream, pack(100));
      chk("early_mult_en", mult_en, 0);
      send_frame(200, 209, 1'b1);
      repeat (2) @(negedge clk);
      chk("early_reload_en", mult_en, 1);
      pulse_ack();
      @(negedge clk);
      chk("early_rel_en", mult_en, 0);

      // Missing in_last
      send_frame(300, 309, 1'b0);
      @(negedge clk);
      chk("miss_err_hi", frame_err, 1);
      @(negedge clk);
      chk("miss_err_lo", frame_err, 0);
      repeat (2) @(negedge clk);
      chk("miss_mult_en", mult_en, 0);
      chk("miss_in_ready", in_ready, 1);
      chk("miss_mat_a", matrix_a_stream, pack(200));

      // Reload something so the mid-frame reset has outputs to clear
      send_frame(400, 409, 1'b1);
      repeat (2) @(negedge clk);
      chk("pre_rst_en", mult_en, 1);

      // Mid-frame reset after 7 beats
      for (int k = 0; k < 7; k++) send_beat(500 + k, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_mult_en", mult_en, 0);
      chk("mid_rst_mat_a", matrix_a_stream, 0);
      chk("mid_rst_mat_b", matrix_b_stream, 0);
      rst = 1'b0;
      send_frame(600, 609, 1'b1);
      repeat (2) @(negedge clk);
      chk("post_mid_rst_en", mult_en, 1);
      chk("post_mid_rst_mat_b", matrix_b_stream, pack(609));

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end
endmodule
